// File: rtl/miner_job_sequencer.sv
// miner_job_sequencer: programs the miner MMIO block for a job, polls to completion and returns the result.
module miner_job_sequencer #(
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
  parameter int unsigned POLL_GAP   = 8,
  parameter int unsigned POLL_LIMIT = 1_000_000
) (
  input  logic         clk_100,
  input  logic         rst_n_raw,
  input  logic         job_valid,
  output logic         job_ready,
  input  logic [639:0] job_header,
  input  logic [255:0] job_target,
  input  logic [31:0]  job_max_nonce,
  output logic         result_valid,
  input  logic         result_ready,
  output logic         result_found,
  output logic         result_exhausted,
  output logic         result_timeout,
  output logic [31:0]  result_nonce,
  output logic [255:0] result_hash,
  output logic         busy,
  output logic         mem_valid,
  output logic [31:0]  mem_addr,
  output logic [31:0]  mem_wdata,
  output logic [3:0]   mem_wstrb,
  input  logic         mem_ready,
  input  logic [31:0]  mem_rdata
);
  typedef enum logic [3:0] {
    IDLE, WR_MAXN, WR_TGT, WR_HDR, WR_START, POLL_WAIT, POLL, RD_NONCE, RD_HASH, RESULT
  } state_t;
  localparam int GW = $clog2(POLL_GAP + 1);
  state_t         state_q, state_d;
  logic           mem_valid_q, mem_valid_d;
  logic [4:0]     word_q, word_d;
  logic [31:0]    poll_q, poll_d;
  logic [GW-1:0]  gap_q, gap_d;
  logic [31:0]    maxn_q, maxn_d;
  logic [255:0]   tgt_q, tgt_d;
  logic [639:0]   hdr_q, hdr_d;
  logic           found_q, found_d, exh_q, exh_d, tmo_q, tmo_d;
  logic [31:0]    nonce_q, nonce_d;
  logic [255:0]   hash_q, hash_d;
  logic [7:0]     offset;
  logic           wr;
  logic [31:0]    wdata;
  logic           done;
  assign done             = mem_valid_q && mem_ready;
  assign job_ready        = rst_n_raw && state_q == IDLE;
  assign busy             = state_q != IDLE;
  assign result_valid     = state_q == RESULT;
  assign result_found     = found_q;
  assign result_exhausted = exh_q;
  assign result_timeout   = tmo_q;
  assign result_nonce     = nonce_q;
  assign result_hash      = hash_q;
  assign mem_valid        = mem_valid_q;
  assign mem_addr         = mem_valid_q ? BASE_ADDR + {24'h0, offset} : 32'h0;
  assign mem_wdata        = (mem_valid_q && wr) ? wdata : 32'h0;
  assign mem_wstrb        = {4{mem_valid_q && wr}};
  always_comb begin
    state_d     = state_q;
    mem_valid_d = mem_valid_q;
    word_d      = word_q;
    poll_d      = poll_q;
    gap_d       = gap_q;
    maxn_d      = maxn_q;
    tgt_d       = tgt_q;
    hdr_d       = hdr_q;
    found_d     = found_q;
    exh_d       = exh_q;
    tmo_d       = tmo_q;
    nonce_d     = nonce_q;
    hash_d      = hash_q;
    offset      = 8'h00;
    wr          = 1'b0;
    wdata       = 32'h0;
    // every bus transaction is preceded by one idle cycle of mem_valid
    if (done) mem_valid_d = 1'b0;
    else if (!(state_q inside {IDLE, POLL_WAIT, RESULT})) mem_valid_d = 1'b1;
    case (state_q)
      IDLE: if (job_valid) begin
        state_d = WR_MAXN;
        maxn_d  = job_max_nonce;
        tgt_d   = job_target;
        hdr_d   = job_header;
        poll_d  = '0;
        found_d = 1'b0;
        exh_d   = 1'b0;
        tmo_d   = 1'b0;
        nonce_d = '0;
        hash_d  = '0;
      end
      WR_MAXN: begin
        offset = 8'h04;
        wr     = 1'b1;
        wdata  = maxn_q;
        if (done) state_d = WR_TGT;
      end
      WR_TGT: begin
        offset = 8'h30 + {1'b0, word_q, 2'b00};
        wr     = 1'b1;
        wdata  = tgt_q[255:224];
        if (done) begin
          tgt_d   = {tgt_q[223:0], 32'h0};
          word_d  = word_q + 5'd1;
          state_d = word_q == 5'd7 ? WR_HDR : WR_TGT;
        end
      end
      WR_HDR: begin
        offset = 8'h50 + {1'b0, word_q, 2'b00};
        wr     = 1'b1;
        wdata  = hdr_q[639:608];
        if (done) begin
          hdr_d   = {hdr_q[607:0], 32'h0};
          word_d  = word_q + 5'd1;
          state_d = word_q == 5'd19 ? WR_START : WR_HDR;
        end
      end
      WR_START: begin
        wr    = 1'b1;
        wdata = 32'h1;
        if (done) state_d = POLL_WAIT;
      end
      POLL_WAIT: if (gap_q == GW'(POLL_GAP - 1)) begin
        state_d     = POLL;
        mem_valid_d = 1'b1;
      end else gap_d = gap_q + 1'b1;
      POLL: if (done) begin
        if (!mem_rdata[1] && (mem_rdata[2] || mem_rdata[3])) begin
          found_d = mem_rdata[2];
          exh_d   = mem_rdata[3];
          state_d = RD_NONCE;
        end else begin
          poll_d = poll_q + 32'd1;
          if (POLL_LIMIT != 0 && poll_d == 32'(POLL_LIMIT)) begin
            tmo_d   = 1'b1;
            state_d = RESULT;
          end else state_d = POLL_WAIT;
        end
      end
      RD_NONCE: begin
        offset = 8'h08;
        if (done) begin
          nonce_d = mem_rdata;
          state_d = RD_HASH;
        end
      end
      RD_HASH: begin
        offset = 8'h0C + {1'b0, word_q, 2'b00};
        if (done) begin
          hash_d  = {hash_q[223:0], mem_rdata};
          word_d  = word_q + 5'd1;
          state_d = word_q == 5'd7 ? RESULT : RD_HASH;
        end
      end
      RESULT: if (result_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) begin
      word_d = '0;
      gap_d  = '0;
    end
  end
  always_ff @(posedge clk_100 or negedge rst_n_raw) begin
    if (!rst_n_raw) begin
      state_q     <= IDLE;
      mem_valid_q <= 1'b0;
      word_q      <= '0;
      poll_q      <= '0;
      gap_q       <= '0;
      maxn_q      <= '0;
      tgt_q       <= '0;
      hdr_q       <= '0;
      found_q     <= 1'b0;
      exh_q       <= 1'b0;
      tmo_q       <= 1'b0;
      nonce_q     <= '0;
      hash_q      <= '0;
    end else begin
      state_q     <= state_d;
      mem_valid_q <= mem_valid_d;
      word_q      <= word_d;
      poll_q      <= poll_d;
      gap_q       <= gap_d;
      maxn_q      <= maxn_d;
      tgt_q       <= tgt_d;
      hdr_q       <= hdr_d;
      found_q     <= found_d;
      exh_q       <= exh_d;
      tmo_q       <= tmo_d;
      nonce_q     <= nonce_d;
      hash_q      <= hash_d;
    end
  end
endmodule

// File: tb/tb_miner_job_sequencer.sv
// tb_miner_job_sequencer: random jobs against a model miner, checked with a transaction-list reference model.
module tb_miner_job_sequencer;
  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int GAP = 4, LIMIT = 6;
  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    int          c;
  } txn_t;
  logic clk_100 = 1'b0, rst_n_raw = 1'b0;
  logic job_valid, job_ready, result_valid, result_ready;
  logic [639:0] job_header;
  logic [255:0] job_target, result_hash;
  logic [31:0] job_max_nonce, result_nonce;
  logic result_found, result_exhausted, result_timeout, busy;
  logic mem_valid, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0] mem_wstrb;
  int checks = 0, errors = 0;
  int cyc = 0, acc_cyc = 0, viol = 0;
  int wait_n = 0, wcnt = 0, pcnt = 0, pcnt0 = 0, fin = 0;
  logic [3:0] fin_st = 4'h0;
  logic [31:0] m_nonce = 32'h0;
  logic [255:0] m_hash = '0;
  txn_t txq[$];
  logic pv = 1'b0, phs = 1'b0;
  logic [31:0] pa = 32'h0, pd = 32'h0;
  logic [3:0] ps = 4'h0;
  logic [31:0] off;
  logic [255:0] sh;
  int n;

  always #5 clk_100 = ~clk_100;

  miner_job_sequencer #(.BASE_ADDR(BASE), .POLL_GAP(GAP), .POLL_LIMIT(LIMIT)) dut (
    .clk_100(clk_100), .rst_n_raw(rst_n_raw),
    .job_valid(job_valid), .job_ready(job_ready), .job_header(job_header),
    .job_target(job_target), .job_max_nonce(job_max_nonce),
    .result_valid(result_valid), .result_ready(result_ready),
    .result_found(result_found), .result_exhausted(result_exhausted),
    .result_timeout(result_timeout), .result_nonce(result_nonce), .result_hash(result_hash),
    .busy(busy), .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  // Model miner: non-final polls cycle through idle / busy / busy-with-found-bit
  assign mem_ready = mem_valid && (wcnt >= wait_n);
  always_comb begin
    off = mem_addr - BASE;
    n = pcnt - pcnt0 + 1;
    sh = '0;
    mem_rdata = 32'h0;
    if (off == 32'h0)
      mem_rdata = (fin != 0 && n >= fin) ? {28'h0, fin_st} :
                  (n % 3 == 1) ? 32'h0 : (n % 3 == 2) ? 32'h2 : 32'h6;
    else if (off == 32'h8) mem_rdata = m_nonce;
    else if (off >= 32'hC && off <= 32'h28) begin
      sh = m_hash << (32 * ((off - 32'hC) / 4));
      mem_rdata = sh[255:224];
    end
  end

  always @(posedge clk_100) begin
    if (!rst_n_raw) begin
      pv <= 1'b0;
      phs <= 1'b0;
      wcnt <= 0;
    end else begin
      if (pv && !phs && (!mem_valid || mem_addr !== pa || mem_wdata !== pd || mem_wstrb !== ps))
        viol <= viol + 1;
      if (phs && mem_valid) viol <= viol + 1;
      pv <= mem_valid;
      phs <= mem_valid && mem_ready;
      pa <= mem_addr;
      pd <= mem_wdata;
      ps <= mem_wstrb;
      wcnt <= (mem_valid && !mem_ready) ? wcnt + 1 : 0;
      if (mem_valid && mem_ready) begin
        txq.push_back(txn_t'{mem_addr, mem_wdata, mem_wstrb, cyc});
        if (mem_addr == BASE && mem_wstrb == 4'h0) pcnt <= pcnt + 1;
      end
      if (job_valid && job_ready) acc_cyc <= cyc;
    end
    cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string p);
    chk({p, " mem_valid"}, 256'(mem_valid), 256'(0));
    chk({p, " mem_addr"}, 256'(mem_addr), 256'(0));
    chk({p, " mem_wdata"}, 256'(mem_wdata), 256'(0));
    chk({p, " mem_wstrb"}, 256'(mem_wstrb), 256'(0));
    chk({p, " job_ready"}, 256'(job_ready), 256'(0));
    chk({p, " busy"}, 256'(busy), 256'(0));
    chk({p, " result_valid"}, 256'(result_valid), 256'(0));
    chk({p, " flags"}, 256'({result_found, result_exhausted, result_timeout}), 256'(0));
    chk({p, " nonce"}, 256'(result_nonce), 256'(0));
    chk({p, " hash"}, result_hash, 256'(0));
  endtask

  task automatic offer_job(output logic [31:0] maxn, output logic [255:0] tgt, output logic [639:0] hdr);
    maxn = $urandom;
    tgt = '0;
    hdr = '0;
    for (int k = 0; k < 8; k++) tgt = {tgt[223:0], 32'($urandom)};
    for (int k = 0; k < 20; k++) hdr = {hdr[607:0], 32'($urandom)};
    pcnt0 = pcnt;
    job_valid = 1'b1;
    job_max_nonce = maxn;
    job_target = tgt;
    job_header = hdr;
    @(negedge clk_100);
    chk("accept busy", 256'(busy), 256'(1));
    chk("accept job_ready", 256'(job_ready), 256'(0));
    job_valid = 1'b0;
    job_max_nonce = ~maxn;
    job_target = ~tgt;
    job_header = ~hdr;
  endtask

  task automatic run_job(input int w, input int finv, input logic [3:0] st, input int hold,
                         input bit tim, input logic [31:0] nonce, input logic [255:0] hash);
    logic [31:0] maxn;
    logic [255:0] tgt;
    logic [639:0] hdr;
    txn_t exp[$];
    int base, p, rv;
    bit term;
    wait_n = w;
    fin = finv;
    fin_st = st;
    m_nonce = nonce;
    m_hash = hash;
    base = txq.size();
    offer_job(maxn, tgt, hdr);
    rv = -1;
    for (int i = 0; i < 20000; i++) begin
      if (result_valid) begin
        rv = cyc;
        break;
      end
      @(negedge clk_100);
    end
    chk("result_valid within budget", 256'(rv >= 0), 256'(1));
    term = finv != 0 && finv <= LIMIT;
    p = term ? finv : LIMIT;
    exp.push_back(txn_t'{BASE + 32'h4, maxn, 4'hF, 0});
    for (int k = 0; k < 8; k++) exp.push_back(txn_t'{BASE + 32'h30 + 32'(4 * k), tgt[255 - 32 * k -: 32], 4'hF, 0});
    for (int k = 0; k < 20; k++) exp.push_back(txn_t'{BASE + 32'h50 + 32'(4 * k), hdr[639 - 32 * k -: 32], 4'hF, 0});
    exp.push_back(txn_t'{BASE, 32'h1, 4'hF, 0});
    for (int k = 0; k < p; k++) exp.push_back(txn_t'{BASE, 32'h0, 4'h0, 0});
    if (term) begin
      exp.push_back(txn_t'{BASE + 32'h8, 32'h0, 4'h0, 0});
      for (int k = 0; k < 8; k++) exp.push_back(txn_t'{BASE + 32'hC + 32'(4 * k), 32'h0, 4'h0, 0});
    end
    chk("txn count", 256'(txq.size() - base), 256'(exp.size()));
    for (int i = 0; i < exp.size() && base + i < txq.size(); i++) begin
      chk($sformatf("txn%0d addr", i), 256'(txq[base + i].a), 256'(exp[i].a));
      chk($sformatf("txn%0d wstrb", i), 256'(txq[base + i].s), 256'(exp[i].s));
      if (exp[i].s != 4'h0) chk($sformatf("txn%0d wdata", i), 256'(txq[base + i].d), 256'(exp[i].d));
    end
    chk("result_found", 256'(result_found), 256'(term && st[2]));
    chk("result_exhausted", 256'(result_exhausted), 256'(term && st[3]));
    chk("result_timeout", 256'(result_timeout), 256'(!term));
    chk("result_nonce", 256'(result_nonce), term ? 256'(nonce) : 256'(0));
    chk("result_hash", result_hash, term ? hash : 256'(0));
    if (txq.size() > base) chk("result_valid latency", 256'(rv), 256'(txq[txq.size() - 1].c + 1));
    if (tim && txq.size() == base + exp.size()) begin
      chk("start write at +60", 256'(txq[base + 29].c), 256'(acc_cyc + 60));
      chk("first poll at +1+GAP", 256'(txq[base + 30].c), 256'(acc_cyc + 61 + GAP));
      if (p > 1) chk("poll spacing", 256'(txq[base + 31].c - txq[base + 30].c), 256'(1 + GAP));
      if (term) chk("readback 18 cycles", 256'(txq[base + 38 + p].c - txq[base + 29 + p].c), 256'(18));
    end
    job_valid = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk_100);
      chk("hold result_valid", 256'(result_valid), 256'(1));
      chk("hold job_ready", 256'(job_ready), 256'(0));
      chk("hold nonce", 256'(result_nonce), term ? 256'(nonce) : 256'(0));
      chk("hold flags", 256'({result_found, result_exhausted, result_timeout}),
          256'({term && st[2], term && st[3], !term}));
    end
    result_ready = 1'b1;
    job_valid = 1'b0;
    @(negedge clk_100);
    result_ready = 1'b0;
    chk("release result_valid", 256'(result_valid), 256'(0));
    chk("release busy", 256'(busy), 256'(0));
    chk("release job_ready", 256'(job_ready), 256'(1));
    chk("no extra txns", 256'(txq.size() - base), 256'(exp.size()));
    chk("bus protocol violations", 256'(viol), 256'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end, observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] maxn;
    logic [255:0] tgt;
    logic [639:0] hdr;
    int base;
    job_valid = 1'b0;
    result_ready = 1'b0;
    job_header = '0;
    job_target = '0;
    job_max_nonce = '0;
    repeat (3) @(negedge clk_100);
    chk_reset("reset");
    rst_n_raw = 1'b1;
    #1 chk("job_ready after release", 256'(job_ready), 256'(1));
    @(negedge clk_100);
    run_job(0, 5, 4'b0100, 10, 1'b1, 32'h0000_1234, {32{8'hA5}});
    run_job(0, 2, 4'b1000, 0, 1'b1, $urandom, {8{$urandom}});
    run_job(3, 3, 4'b0100, 2, 1'b0, 32'h0000_1234, {32{8'hA5}});
    run_job(1, 4, 4'b1100, 0, 1'b0, $urandom, {8{$urandom}});
    run_job(1, 0, 4'b0100, 1, 1'b0, 32'hDEAD_BEEF, {8{32'h5A5A_0F0F}});
    run_job(0, 0, 4'b0100, 0, 1'b1, 32'hDEAD_BEEF, {8{32'h1234_5678}});
    run_job(2, 1, 4'b0101, 0, 1'b0, $urandom, {8{$urandom}});
    wait_n = 3;
    fin = 1;
    fin_st = 4'b0100;
    base = txq.size();
    offer_job(maxn, tgt, hdr);
    for (int i = 0; i < 2000 && !(txq.size() - base >= 16 && mem_valid); i++) @(negedge clk_100);
    chk("pre-reset hdr word7 addr", 256'(mem_addr), 256'(BASE + 32'h6C));
    chk("pre-reset hdr word7 data", 256'(mem_wdata), 256'(hdr[639 - 32 * 7 -: 32]));
    #2 rst_n_raw = 1'b0;
    #1 chk_reset("mid-job reset");
    @(negedge clk_100);
    chk_reset("held reset");
    @(negedge clk_100);
    rst_n_raw = 1'b1;
    #1 chk("job_ready after mid-job reset", 256'(job_ready), 256'(1));
    @(negedge clk_100);
    run_job(0, 1, 4'b0100, 0, 1'b1, $urandom, {8{$urandom}});
    for (int j = 0; j < 3; j++)
      run_job($urandom_range(0, 2), $urandom_range(1, 7),
              {2'($urandom_range(1, 3)), 1'b0, 1'($urandom)}, $urandom_range(0, 3), 1'b0,
              $urandom, {8{$urandom}});
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/miner_job_sequencer.md
# miner_job_sequencer

Hardware bus initiator that programs and runs the bitcoin_miner MMIO block without CPU involvement. It accepts a mining job (header template, target, max nonce) on a valid/ready port and replays the register programming sequence as picorv32-native bus transactions. It polls the control/status register until the search ends, reads back nonce and hash, and presents a result record. It sits on the miner MMIO bus in place of, or arbitrated alongside, the CPU.

## Interface
Parameters:
- BASE_ADDR, 32'h8000_0000, miner MMIO base; all offsets below are added to it
- POLL_GAP, 8, idle cycles between consecutive status polls (and before the first poll); minimum 4
- POLL_LIMIT, 1_000_000, maximum status polls before timeout; 0 disables timeout

Ports:
- clk_100  in  1  clock
- rst_n_raw  in  1  reset, asynchronous, active-low
- job_valid  in  1  job offered
- job_ready  out  1  sequencer idle, job accepted on job_valid&&job_ready
- job_header  in  640  header template, bits [639:608] are word 0
- job_target  in  256  target, bits [255:224] are word 0
- job_max_nonce  in  32  max nonce
- result_valid  out  1  result record held stable
- result_ready  in  1  consumer accepts result
- result_found / result_exhausted / result_timeout  out  1 each  end-of-search cause
- result_nonce  out  32  nonce read from offset 0x08
- result_hash  out  256  hash read from 0x0C..0x28, 0x0C in [255:224]
- busy  out  1  high from job acceptance until result accepted
- mem_valid  out  1  bus request
- mem_addr  out  32  bus address
- mem_wdata  out  32  write data
- mem_wstrb  out  4  4'hF writes, 4'h0 reads
- mem_ready  in  1  responder handshake (may be combinational)
- mem_rdata  in  32  read data, valid on handshake cycle

## Operation
- States: IDLE, WR_MAXN, WR_TGT, WR_HDR, WR_START, POLL_WAIT, POLL, RD_NONCE, RD_HASH, RESULT.
- IDLE: job_ready=1; on job_valid, latch all three job fields, go WR_MAXN. Inputs ignored after latch.
- WR_MAXN: write max nonce to 0x04.
- WR_TGT: 8 writes 0x30,0x34..0x4C, word index k = target[255-32k -: 32].
- WR_HDR: 20 writes 0x50..0x9C, same ordering on header.
- WR_START: write 32'h1 to 0x00.
- POLL_WAIT: count POLL_GAP cycles, then POLL.
- POLL: read 0x00; busy=rdata[1], found=rdata[2], exhausted=rdata[3]. If busy==0 and (found|exhausted): latch found/exhausted, go RD_NONCE. Else increment poll count; if POLL_LIMIT!=0 and count==POLL_LIMIT, set result_timeout, skip readback (nonce/hash=0), go RESULT; else POLL_WAIT.
- found and exhausted both set: report both as read.
- RD_NONCE: read 0x08. RD_HASH: 8 reads 0x0C..0x28.
- RESULT: result_valid=1, fields stable; on result_ready go IDLE, clear result_valid and busy. Next job may be accepted the cycle after.
- Word counter 5 bits, poll counter 32 bits, gap counter sized to POLL_GAP; all clear on state entry.

## Timing
- Bus rule: mem_valid asserted with addr/wdata/wstrb stable until the cycle mem_valid&&mem_ready; transfer completes that cycle; mem_valid is low for exactly one cycle between transactions.
- Zero-wait responder: 2 cycles per transaction; programming (30 writes) = 60 cycles from acceptance to start-write completion; first poll 1+POLL_GAP cycles later.
- Readback with zero-wait responder: 9 reads = 18 cycles; result_valid rises the cycle after the last hash-read handshake.
- Wait states: any number of mem_ready-low cycles stretch the transaction; no timeout on a single transaction.
- Reset (asynchronous, any state, mid-transaction included): state IDLE, mem_valid=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, job_ready=0 during reset then 1 the first cycle after release, result_valid=0, all result fields 0, busy=0, counters 0.

## Test plan
- Full job, zero-wait model miner finding on 5th poll with nonce 32'h0000_1234, hash 256'hA5..: exactly 30 writes in order 0x04,0x30..0x4C,0x50..0x9C,0x00; result_found=1, nonce and hash match, result_valid 1 cycle after last read.
- Exhausted case: status returns 4'b1000 -> result_exhausted=1, result_found=0, nonce/hash read back.
- Responder inserts 3 wait cycles on every transfer -> addr/wdata/wstrb stable during waits, no duplicated or skipped transfers, same final result.
- POLL_LIMIT=3, status always busy -> exactly 3 polls, result_timeout=1, nonce=0, hash=0, no readback reads.
- result_ready held low 10 cycles -> fields stable, job_ready=0; new job_valid ignored until result accepted.
- rst_n_raw pulsed during WR_HDR word 7 -> mem_valid falls asynchronously, all outputs at reset values; next job runs full 30-write sequence from 0x04.
